// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Inter-stage pipeline register with valid/ready handshake, hazard stall,
// synchronous flush and a two-entry (main + skid) buffer.
//
// Ports:
//   clk        stage clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream entry valid
//   in_ready   stage can accept an entry (driven from state only)
//   in_ctrl    incoming control bundle (CTRL_W)
//   in_data    incoming payload (DATA_W)
//   stall      hazard hold of the output entry
//   flush      synchronous kill of all held entries
//   out_valid  output entry valid
//   out_ready  downstream accepts the output entry
//   out_ctrl   output control bundle, zero whenever out_valid = 0
//   out_data   output payload, holds last value when out_valid = 0
//   occupancy  number of held entries (0..2)
//
// state   | meaning
// --------+-------------------------------------------------
// S_EMPTY | nothing held, main ctrl is zero
// S_ONE   | main holds the oldest entry, skid empty
// S_FULL  | main holds the oldest entry, skid holds the next

module pipe_stage_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic main_ctrl_clr;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // outputs depend on the state register only, so in_ready has no
  // combinational path from out_ready or stall
  always_comb begin
    in_ready  = (state_q != S_FULL);
    out_valid = (state_q != S_EMPTY);
    occupancy = state_q;
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~stall;

  // next state and datapath load selects
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    main_ctrl_clr  = 1'b0;
    if (flush) begin
      // incoming entry is dropped; a concurrent out_fire was delivered
      state_d       = S_EMPTY;
      main_ctrl_clr = 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d      = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (out_fire) begin
            state_d       = S_EMPTY;
            main_ctrl_clr = 1'b1;
          end else if (in_fire) begin
            state_d   = S_FULL;
            load_skid = 1'b1;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            state_d        = S_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_d       = S_EMPTY;
          main_ctrl_clr = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (load_main_in) begin
      main_ctrl_d = in_ctrl;
      main_data_d = in_data;
    end else if (load_main_skid) begin
      main_ctrl_d = skid_ctrl_q;
      main_data_d = skid_data_q;
    end
    // bubble: ctrl goes to zero on the same edge main becomes invalid
    if (main_ctrl_clr) begin
      main_ctrl_d = '0;
    end
    if (load_skid) begin
      skid_ctrl_d = in_ctrl;
      skid_data_d = in_data;
    end
    if (flush || load_main_skid) begin
      skid_ctrl_d = '0;
    end
  end

  // payload registers are only cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_ctrl = main_ctrl_q;
  assign out_data = main_data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios plus random traffic,
// checked against a queue-based model of the stage contents.

module tb_pipe_stage_reg;

  localparam int DW = 160;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          stall;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];     // entries held by the stage, oldest first
  logic [DW-1:0] last_data; // payload last presented on the output
  int            n_total = 0;
  int            n_bad   = 0;
  int            n_deliv = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [CW-1:0] ec;
    ec = (mq.size() > 0) ? mq[0].c : '0;
    check_val({tag, "_ovalid"}, DW'(out_valid), DW'(mq.size() > 0));
    check_val({tag, "_iready"}, DW'(in_ready), DW'(mq.size() < 2));
    check_val({tag, "_occ"}, DW'(occupancy), DW'(mq.size()));
    check_val({tag, "_octrl"}, DW'(out_ctrl), DW'(ec));
    check_val({tag, "_odata"}, out_data, last_data);
  endtask

  // one cycle: check current outputs, drive inputs, advance the model
  task automatic cyc(input string tag, input bit iv, input logic [CW-1:0] ic,
                     input logic [DW-1:0] id, input bit ordy, input bit st,
                     input bit fl);
    bit   ifire, ofire;
    ent_t e;
    @(negedge clk);
    check_model(tag);
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    ifire = iv && (mq.size() < 2);
    ofire = (mq.size() > 0) && ordy && !st;
    if (ofire) n_deliv++;
    if (fl) begin
      mq.delete();
    end else begin
      if (ofire) void'(mq.pop_front());
      if (ifire) begin
        e.c = ic;
        e.d = id;
        mq.push_back(e);
      end
    end
    if (mq.size() > 0) last_data = mq[0].d;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    last_data = '0;

    // reset values
    #3;
    check_val("rst_ovalid", DW'(out_valid), '0);
    check_val("rst_octrl", DW'(out_ctrl), '0);
    check_val("rst_odata", out_data, '0);
    check_val("rst_iready", DW'(in_ready), DW'(1));
    check_val("rst_occ", DW'(occupancy), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // stream 1..4
    for (int i = 1; i <= 4; i++) cyc("strm", 1'b1, 12'hFFF, DW'(i), 1'b1, 1'b0, 1'b0);
    idle("strm_tail", 2);

    // backpressure into the skid
    cyc("bp", 1'b1, 12'h0A1, DW'('h10), 1'b1, 1'b0, 1'b0);
    cyc("bp", 1'b1, 12'h0A2, DW'('h11), 1'b0, 1'b0, 1'b0);
    cyc("bp", 1'b1, 12'h0A3, DW'('h12), 1'b0, 1'b0, 1'b0);
    cyc("bp", 1'b1, 12'h0A3, DW'('h12), 1'b0, 1'b0, 1'b0);
    cyc("bp", 1'b1, 12'h0A3, DW'('h12), 1'b1, 1'b0, 1'b0);
    cyc("bp", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle("bp_tail", 3);

    // stall holds main, skid fills
    cyc("stl", 1'b1, 12'h123, DW'('h20), 1'b1, 1'b0, 1'b0);
    cyc("stl", 1'b1, 12'h124, DW'('h21), 1'b1, 1'b1, 1'b0);
    cyc("stl", 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    idle("stl_tail", 3);

    // flush from FULL with an input presented
    cyc("fl", 1'b1, 12'h301, DW'('h30), 1'b0, 1'b0, 1'b0);
    cyc("fl", 1'b1, 12'h302, DW'('h31), 1'b0, 1'b0, 1'b0);
    cyc("fl", 1'b1, 12'h303, DW'('h32), 1'b0, 1'b0, 1'b1);
    idle("fl_tail", 3);

    // flush + stall + input
    cyc("fsi", 1'b1, 12'h401, DW'('h40), 1'b0, 1'b0, 1'b0);
    cyc("fsi", 1'b1, 12'h402, DW'('h41), 1'b1, 1'b1, 1'b1);
    idle("fsi_tail", 2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", 1'($urandom_range(0, 3) != 0), 12'($urandom), rnd_data(),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) == 0),
          1'($urandom_range(0, 19) == 0));
    end
    idle("rnd_tail", 3);

    // asynchronous reset while FULL
    cyc("ar", 1'b1, 12'h501, DW'('h50), 1'b0, 1'b0, 1'b0);
    cyc("ar", 1'b1, 12'h502, DW'('h51), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check_val("ar_pre_occ", DW'(occupancy), DW'(mq.size()));
    rst_n = 1'b0;
    #1;
    check_val("ar_ovalid", DW'(out_valid), '0);
    check_val("ar_octrl", DW'(out_ctrl), '0);
    check_val("ar_odata", out_data, '0);
    check_val("ar_iready", DW'(in_ready), DW'(1));
    check_val("ar_occ", DW'(occupancy), '0);
    mq.delete();
    last_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_ar", 1'b1, 12'h601, DW'('h60), 1'b1, 1'b0, 1'b0);
    idle("post_ar_tail", 3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, hazard stall, synchronous flush and a two-entry skid buffer. It replaces the fixed free-running stage latches between decode/execute, execute/memory and memory/writeback. A flush inserts a bubble whose control bits are forced to zero, so no RegWrite or Mem_Write can leak downstream. Full throughput is one transfer per cycle with a registered ready path.

## Interface
- DATA_W, 160: width of the datapath payload (PC, instruction, operands, immediates, register indices).
- CTRL_W, 12: width of the control bundle (RegWrite, MemToReg, Mem_Read, Mem_Write, jump, RegDst, ALUsrc, ALUop, ...); zeroed on bubble.

Ports:
- clk  input  1  stage clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream stage presents a valid entry.
- in_ready  output  1  stage can accept an entry this cycle; registered.
- in_ctrl  input  CTRL_W  control bundle of the incoming entry.
- in_data  input  DATA_W  payload of the incoming entry.
- stall  input  1  hazard unit holds the output entry; equivalent to out_ready = 0.
- flush  input  1  synchronous kill of all held entries (branch/jump redirect).
- out_valid  output  1  output entry is valid.
- out_ready  input  1  downstream stage accepts the output entry.
- out_ctrl  output  CTRL_W  control bundle of the output entry; all-zero whenever out_valid = 0.
- out_data  output  DATA_W  payload of the output entry; holds its last value when out_valid = 0.
- occupancy  output  2  number of held entries (0, 1 or 2).

## Operation
- Storage: main register (drives out_*) and skid register; each has a valid bit.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready & ~stall.
- in_ready = ~skid_valid, taken from the register (no combinational path from out_ready or stall).
- States, encoded by occupancy:
  - EMPTY (0): in_fire -> ONE, main loads input.
  - ONE (1): in_fire & out_fire -> ONE, main loads input. out_fire only -> EMPTY. in_fire only -> FULL, skid loads input. Neither -> ONE, hold.
  - FULL (2): in_ready = 0. out_fire -> ONE, main loads skid, skid invalidated. Otherwise hold.
- Ordering: entries leave in acceptance order. The skid entry always leaves after the main entry.
- Bubble rule: whenever main becomes invalid (drain, flush or reset), main ctrl is cleared to 0 in the same edge.
- Flush has the highest priority. On an edge with flush = 1:
  - both valids clear and both ctrl fields clear;
  - any in_fire in that cycle is discarded;
  - out_fire in that cycle still counts as delivered to downstream;
  - next state is EMPTY.
- Stall with flush: flush wins.
- Stall alone: main and skid hold. Upstream can still fill the skid if it is empty.
- Data fields are never cleared except by reset.

## Timing
- Reset (rst_n low, asynchronous): out_valid = 0, out_ctrl = 0, out_data = 0, skid cleared, occupancy = 0, in_ready = 1.
- Release: first edge with rst_n = 1 may accept input.
- Latency: an entry accepted at edge N is visible on out_* after edge N (one cycle) when the stage was EMPTY, or was ONE with out_fire.
- Throughput: one transfer per cycle sustained with out_ready = 1 and stall = 0.
- After a single blocked output cycle, in_ready deasserts one cycle later. The skid absorbs the entry accepted in the cycle the block appeared.
- Flush: out_valid = 0, out_ctrl = 0, occupancy = 0 and in_ready = 1 in the cycle after flush is sampled.
- Reset asserted mid-stream: all entries are lost immediately, with no edge needed.

## Test plan
- Reset and stream:
  - Stimulus: rst_n low; check outputs. Then drive 4 entries, data 0x1..0x4, ctrl 0xFFF, out_ready = 1.
  - Response: during reset, out_valid = 0, out_ctrl = 0, out_data = 0, in_ready = 1. After release, out_data = 0x1..0x4 on consecutive cycles, each one cycle after input; occupancy stays 1 and in_ready stays 1.
- Backpressure and skid:
  - Stimulus: stream data 0x10, 0x11, 0x12; drop out_ready after 0x10 appears; hold low 3 cycles, then raise.
  - Response: occupancy goes 1 -> 2; in_ready goes 0 one cycle after the block; no entry lost or duplicated; output order 0x10, 0x11, 0x12.
- Stall:
  - Stimulus: stall = 1 for 2 cycles while out_ready = 1 and main holds 0x20.
  - Response: out_data = 0x20 held, no out_fire, the next input lands in the skid. After stall drops, 0x20 is followed by the skid entry.
- Flush with FULL state:
  - Stimulus: FULL with 0x30 and 0x31; pulse flush for 1 cycle while in_valid = 1 with 0x32.
  - Response: next cycle out_valid = 0, out_ctrl = 0x000, occupancy = 0, in_ready = 1; none of 0x30, 0x31 or 0x32 ever emerge.
- Flush plus stall plus input:
  - Stimulus: flush = stall = 1 with in_valid = 1.
  - Response: identical to flush alone, with the stage EMPTY afterwards.
- Asynchronous reset mid-operation:
  - Stimulus: drop rst_n between edges while occupancy = 2.
  - Response: outputs go to reset values before the next edge, and in_ready = 1 immediately.
